// File: rtl/imem_arbiter_pkg.sv
// imem_arbiter_pkg: shared encodings for the instruction-memory arbiter.
// State, owner tag and default widths used by the top and its counter.
package imem_arbiter_pkg;

   localparam int ADDR_W_DEF = 16;
   localparam int DATA_W_DEF = 16;
   localparam int WAIT_W     = 4;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      LOAD  = 2'd2
   } arb_state_e;

   localparam logic OWN_FETCH = 1'b0;
   localparam logic OWN_AUX   = 1'b1;

   typedef struct packed {
      logic valid;
      logic owner;
   } rd_tag_t;

endpackage

// File: rtl/imem_starve_counter.sv
// imem_starve_counter: saturating count of cycles the aux port was refused,
// flagging when the refusal budget is used up.
module imem_starve_counter
   import imem_arbiter_pkg::*;
#(
   parameter int MAX_WAIT = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic count_en_i,
   output logic at_max_o
);

   logic [WAIT_W-1:0] cnt_q;
   logic [WAIT_W-1:0] cnt_d;

   // Anything other than a refused aux request in RUN restarts the count.
   always_comb begin
      cnt_d = '0;
      if (count_en_i) begin
         if (cnt_q != '1) begin
            cnt_d = cnt_q + WAIT_W'(1);
         end else begin
            cnt_d = cnt_q;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign at_max_o = (cnt_q == WAIT_W'(MAX_WAIT));

endmodule

// File: rtl/imem_arbiter.sv
// imem_arbiter: shares one instruction memory between the fetch stage and
// the aux/loader port, and sequences exclusive program loading.
module imem_arbiter
   import imem_arbiter_pkg::*;
#(
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int DATA_W   = DATA_W_DEF,
   parameter int MAX_WAIT = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              fetch_req,
   input  logic [ADDR_W-1:0] fetch_addr,
   output logic              fetch_gnt,
   output logic [DATA_W-1:0] fetch_rdata,
   output logic              fetch_rvalid,
   input  logic              aux_req,
   input  logic              aux_we,
   input  logic [ADDR_W-1:0] aux_addr,
   input  logic [DATA_W-1:0] aux_wdata,
   output logic              aux_gnt,
   output logic [DATA_W-1:0] aux_rdata,
   output logic              aux_rvalid,
   input  logic              load_mode,
   output logic              cpu_hold,
   output logic [ADDR_W-1:0] mem_rdaddress,
   output logic [ADDR_W-1:0] mem_wraddress,
   output logic              mem_wren,
   output logic [DATA_W-1:0] mem_data,
   input  logic [DATA_W-1:0] mem_q
);

   arb_state_e state_q;
   arb_state_e state_d;
   rd_tag_t    tag_q;
   rd_tag_t    tag_d;
   logic       hold_q;
   logic       hold_d;
   logic       at_max;
   logic       count_en;
   logic       aux_rd_gnt;

   always_comb begin
      state_d   = state_q;
      fetch_gnt = 1'b0;
      aux_gnt   = 1'b0;
      unique case (state_q)
         RUN: begin
            aux_gnt   = aux_req & (~fetch_req | at_max);
            // A load request blocks new fetches so the drain stays short.
            fetch_gnt = fetch_req & ~aux_gnt & ~load_mode;
            if (load_mode) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            state_d = LOAD;
         end
         LOAD: begin
            aux_gnt = aux_req;
            if (!load_mode) begin
               state_d = RUN;
            end
         end
         default: begin
            state_d = RUN;
         end
      endcase
      if (rst) begin
         fetch_gnt = 1'b0;
         aux_gnt   = 1'b0;
      end
   end

   assign count_en   = (state_q == RUN) & aux_req & ~aux_gnt;
   assign aux_rd_gnt = aux_gnt & ~aux_we;

   imem_starve_counter #(
      .MAX_WAIT (MAX_WAIT)
   ) u_starve (
      .clk        (clk),
      .rst        (rst),
      .count_en_i (count_en),
      .at_max_o   (at_max)
   );

   always_comb begin
      tag_d.valid = fetch_gnt | aux_rd_gnt;
      tag_d.owner = aux_rd_gnt ? OWN_AUX : OWN_FETCH;
      hold_d      = (state_q != RUN);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RUN;
         tag_q   <= '0;
         hold_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         tag_q   <= tag_d;
         hold_q  <= hold_d;
      end
   end

   assign mem_rdaddress = aux_rd_gnt ? aux_addr : fetch_addr;
   assign mem_wraddress = aux_addr;
   assign mem_data      = aux_wdata;
   assign mem_wren      = aux_gnt & aux_we;

   // Reset in the return cycle swallows the pending read.
   assign fetch_rvalid = tag_q.valid & (tag_q.owner == OWN_FETCH) & ~rst;
   assign aux_rvalid   = tag_q.valid & (tag_q.owner == OWN_AUX) & ~rst;
   assign fetch_rdata  = mem_q;
   assign aux_rdata    = mem_q;
   assign cpu_hold     = hold_q;

endmodule

// File: tb/tb_imem_arbiter.sv
// tb_imem_arbiter: directed and random checks of imem_arbiter against a
// cycle-level behavioural model with its own shadow memory.
module tb_imem_arbiter;

   localparam int MAX_WAIT = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        fetch_req = 1'b0;
   logic [15:0] fetch_addr = '0;
   logic        fetch_gnt;
   logic [15:0] fetch_rdata;
   logic        fetch_rvalid;
   logic        aux_req = 1'b0;
   logic        aux_we = 1'b0;
   logic [15:0] aux_addr = '0;
   logic [15:0] aux_wdata = '0;
   logic        aux_gnt;
   logic [15:0] aux_rdata;
   logic        aux_rvalid;
   logic        load_mode = 1'b0;
   logic        cpu_hold;
   logic [15:0] mem_rdaddress;
   logic [15:0] mem_wraddress;
   logic        mem_wren;
   logic [15:0] mem_data;
   logic [15:0] mem_q;

   imem_arbiter #(
      .ADDR_W   (16),
      .DATA_W   (16),
      .MAX_WAIT (MAX_WAIT)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .fetch_req     (fetch_req),
      .fetch_addr    (fetch_addr),
      .fetch_gnt     (fetch_gnt),
      .fetch_rdata   (fetch_rdata),
      .fetch_rvalid  (fetch_rvalid),
      .aux_req       (aux_req),
      .aux_we        (aux_we),
      .aux_addr      (aux_addr),
      .aux_wdata     (aux_wdata),
      .aux_gnt       (aux_gnt),
      .aux_rdata     (aux_rdata),
      .aux_rvalid    (aux_rvalid),
      .load_mode     (load_mode),
      .cpu_hold      (cpu_hold),
      .mem_rdaddress (mem_rdaddress),
      .mem_wraddress (mem_wraddress),
      .mem_wren      (mem_wren),
      .mem_data      (mem_data),
      .mem_q         (mem_q)
   );

   always #5 clk = ~clk;

   logic [15:0] mem [0:65535];

   always @(posedge clk) begin
      if (mem_wren) mem[mem_wraddress] <= mem_data;
      mem_q <= mem[mem_rdaddress];
   end

   typedef enum int {M_RUN, M_DRAIN, M_LOAD} mph_e;

   logic [15:0] ref_mem [0:65535];
   mph_e        m_ph;
   int          m_refused;
   bit          m_hold;
   bit          p_valid;
   bit          p_fetch;
   logic [15:0] p_data;
   bit          g_f;
   bit          g_a;
   bit          e_fv;
   bit          e_av;
   logic [85:0] exp_v;
   bit          have_eval;
   int          checks;
   int          errors;
   int          cyc;

   function automatic logic [15:0] model_rdaddr();
      return (g_a && !aux_we) ? aux_addr : fetch_addr;
   endfunction

   function automatic void model_eval();
      g_f = 1'b0;
      g_a = 1'b0;
      if (!rst) begin
         case (m_ph)
            M_RUN: begin
               g_a = aux_req && (!fetch_req || m_refused == MAX_WAIT);
               g_f = fetch_req && !g_a && !load_mode;
            end
            M_LOAD: g_a = aux_req;
            default: ;
         endcase
      end
      e_fv  = p_valid && p_fetch && !rst;
      e_av  = p_valid && !p_fetch && !rst;
      exp_v = {g_f, g_a, g_a && aux_we, model_rdaddr(), aux_addr, aux_wdata,
               e_fv, e_av, m_hold,
               e_fv ? p_data : 16'h0, e_av ? p_data : 16'h0};
   endfunction

   function automatic void model_commit();
      if (rst) begin
         m_ph      = M_RUN;
         m_refused = 0;
         m_hold    = 1'b0;
         p_valid   = 1'b0;
         p_fetch   = 1'b0;
      end else begin
         p_valid = g_f || (g_a && !aux_we);
         p_fetch = g_f;
         p_data  = ref_mem[model_rdaddr()];
         if (g_a && aux_we) ref_mem[aux_addr] = aux_wdata;
         if (m_ph == M_RUN && aux_req && !g_a)
            m_refused = (m_refused < 15) ? m_refused + 1 : 15;
         else
            m_refused = 0;
         m_hold = (m_ph != M_RUN);
         case (m_ph)
            M_RUN:   if (load_mode) m_ph = M_DRAIN;
            M_DRAIN: m_ph = M_LOAD;
            default: if (!load_mode) m_ph = M_RUN;
         endcase
      end
   endfunction

   function automatic logic [85:0] obs_v();
      return {fetch_gnt, aux_gnt, mem_wren, mem_rdaddress, mem_wraddress,
              mem_data, fetch_rvalid, aux_rvalid, cpu_hold,
              e_fv ? fetch_rdata : 16'h0, e_av ? aux_rdata : 16'h0};
   endfunction

   task automatic drive(input bit r, input bit fr, input logic [15:0] fa,
                        input bit ar, input bit aw, input logic [15:0] aa,
                        input logic [15:0] ad, input bit lm);
      if (have_eval) model_commit();
      @(negedge clk);
      rst        = r;
      fetch_req  = fr;
      fetch_addr = fa;
      aux_req    = ar;
      aux_we     = aw;
      aux_addr   = aa;
      aux_wdata  = ad;
      load_mode  = lm;
      #1;
      model_eval();
      have_eval = 1'b1;
      cyc++;
   endtask

   task automatic test_reset();
      drive(1, 0, 0, 0, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0, 0, 0, 0);
      checks++;
      if (obs_v() !== exp_v) begin
         errors++;
         $display("FAIL reset_model cyc=%0d got=%h exp=%h", cyc, obs_v(), exp_v);
      end
      checks++;
      if ({cpu_hold, fetch_rvalid, aux_rvalid} !== 3'b000) begin
         errors++;
         $display("FAIL reset_outputs got=%b exp=000",
                  {cpu_hold, fetch_rvalid, aux_rvalid});
      end
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      checks++;
      if (obs_v() !== exp_v) begin
         errors++;
         $display("FAIL reset_idle cyc=%0d got=%h exp=%h", cyc, obs_v(), exp_v);
      end
   endtask

   task automatic test_fetch_seq();
      logic [15:0] seq [3];
      seq[0] = 16'h1111;
      seq[1] = 16'h2222;
      seq[2] = 16'h3333;
      for (int i = 0; i < 4; i++) begin
         drive(0, i < 3, 16'(i), 0, 0, 0, 0, 0);
         checks++;
         if (obs_v() !== exp_v) begin
            errors++;
            $display("FAIL fetch_seq cyc=%0d got=%h exp=%h", cyc, obs_v(), exp_v);
         end
         if (i > 0) begin
            checks++;
            if (fetch_rvalid !== 1'b1 || fetch_rdata !== seq[i-1] ||
                aux_rvalid !== 1'b0) begin
               errors++;
               $display("FAIL fetch_data i=%0d got=%b/%h exp=1/%h", i,
                        fetch_rvalid, fetch_rdata, seq[i-1]);
            end
         end
      end
   endtask

   task automatic test_starve();
      int refused;
      bit got;
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      for (int pass = 0; pass < 2; pass++) begin
         refused = 0;
         got     = 1'b0;
         for (int k = 0; k < 20 && !got; k++) begin
            drive(0, 1, 16'($urandom_range(0, 255)), 1, 0, 16'h0040, 0, 0);
            checks++;
            if (obs_v() !== exp_v) begin
               errors++;
               $display("FAIL starve cyc=%0d got=%h exp=%h", cyc, obs_v(), exp_v);
            end
            if (pass == 1 && k == 0) begin
               checks++;
               if (aux_rvalid !== 1'b1 || aux_rdata !== 16'hC0DE) begin
                  errors++;
                  $display("FAIL starve_rdata got=%b/%h exp=1/c0de",
                           aux_rvalid, aux_rdata);
               end
            end
            if (aux_gnt === 1'b1) begin
               got = 1'b1;
               checks++;
               if (fetch_gnt !== 1'b0) begin
                  errors++;
                  $display("FAIL starve_excl got=%b exp=0", fetch_gnt);
               end
            end else begin
               refused++;
            end
         end
         checks++;
         if (!got || refused != MAX_WAIT) begin
            errors++;
            $display("FAIL starve_refused pass=%0d got=%0d exp=%0d granted=%0b",
                     pass, refused, MAX_WAIT, got);
         end
      end
      drive(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic test_aux_write();
      drive(0, 0, 0, 1, 1, 16'h0010, 16'hBEEF, 0);
      checks++;
      if (obs_v() !== exp_v || aux_gnt !== 1'b1 || mem_wren !== 1'b1) begin
         errors++;
         $display("FAIL aux_write got=%h exp=%h", obs_v(), exp_v);
      end
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      checks++;
      if (mem_wren !== 1'b0) begin
         errors++;
         $display("FAIL aux_write_pulse got=%b exp=0", mem_wren);
      end
      drive(0, 1, 16'h0010, 0, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      checks++;
      if (obs_v() !== exp_v || fetch_rvalid !== 1'b1 ||
          fetch_rdata !== 16'hBEEF) begin
         errors++;
         $display("FAIL aux_write_readback got=%b/%h exp=1/beef",
                  fetch_rvalid, fetch_rdata);
      end
   endtask

   task automatic test_load();
      drive(0, 1, 16'h0005, 0, 0, 0, 0, 0);
      drive(0, 1, 16'h0006, 0, 0, 0, 0, 1);
      checks++;
      if (obs_v() !== exp_v || fetch_gnt !== 1'b0 || fetch_rvalid !== 1'b1 ||
          fetch_rdata !== 16'h5A5F) begin
         errors++;
         $display("FAIL load_enter got=%h exp=%h", obs_v(), exp_v);
      end
      drive(0, 1, 16'h0006, 0, 0, 0, 0, 1);
      checks++;
      if (obs_v() !== exp_v || fetch_gnt !== 1'b0) begin
         errors++;
         $display("FAIL load_drain got=%h exp=%h", obs_v(), exp_v);
      end
      for (int i = 0; i < 4; i++) begin
         drive(0, 1, 16'h0006, 1, 1, 16'(i), 16'hD000 + 16'(i), 1);
         checks++;
         if (obs_v() !== exp_v || fetch_gnt !== 1'b0 || aux_gnt !== 1'b1 ||
             mem_wren !== 1'b1 || cpu_hold !== 1'b1) begin
            errors++;
            $display("FAIL load_write i=%0d got=%h exp=%h", i, obs_v(), exp_v);
         end
      end
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      checks++;
      if (obs_v() !== exp_v || cpu_hold !== 1'b1) begin
         errors++;
         $display("FAIL load_exit_hold got=%b exp=1", cpu_hold);
      end
      drive(0, 1, 16'h0000, 0, 0, 0, 0, 0);
      checks++;
      if (obs_v() !== exp_v || cpu_hold !== 1'b0 || fetch_gnt !== 1'b1) begin
         errors++;
         $display("FAIL load_release got=%b/%b exp=0/1", cpu_hold, fetch_gnt);
      end
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      checks++;
      if (obs_v() !== exp_v || fetch_rvalid !== 1'b1 ||
          fetch_rdata !== 16'hD000) begin
         errors++;
         $display("FAIL load_readback got=%b/%h exp=1/d000",
                  fetch_rvalid, fetch_rdata);
      end
   endtask

   task automatic test_load_reset();
      drive(0, 0, 0, 0, 0, 0, 0, 1);
      drive(0, 0, 0, 0, 0, 0, 0, 1);
      drive(0, 0, 0, 1, 1, 16'h0020, 16'h6666, 1);
      drive(1, 0, 0, 1, 1, 16'h0021, 16'h7777, 1);
      checks++;
      if (obs_v() !== exp_v || mem_wren !== 1'b0 || aux_gnt !== 1'b0) begin
         errors++;
         $display("FAIL load_reset_write got=%b/%b exp=0/0", mem_wren, aux_gnt);
      end
      drive(0, 1, 16'h0021, 0, 0, 0, 0, 0);
      checks++;
      if (obs_v() !== exp_v || cpu_hold !== 1'b0 || fetch_gnt !== 1'b1) begin
         errors++;
         $display("FAIL load_reset_run got=%b/%b exp=0/1", cpu_hold, fetch_gnt);
      end
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      checks++;
      if (obs_v() !== exp_v || fetch_rdata !== 16'h5A7B) begin
         errors++;
         $display("FAIL load_reset_mem got=%h exp=5a7b", fetch_rdata);
      end
   endtask

   task automatic test_reset_after_grant();
      drive(0, 1, 16'h0003, 0, 0, 0, 0, 0);
      drive(1, 1, 16'h0004, 0, 0, 0, 0, 0);
      checks++;
      if (obs_v() !== exp_v || fetch_rvalid !== 1'b0 || fetch_gnt !== 1'b0) begin
         errors++;
         $display("FAIL rst_grant got=%b/%b exp=0/0", fetch_rvalid, fetch_gnt);
      end
      drive(0, 1, 16'h0004, 1, 0, 16'h0050, 0, 0);
      checks++;
      if (obs_v() !== exp_v || fetch_rvalid !== 1'b0 || cpu_hold !== 1'b0 ||
          fetch_gnt !== 1'b1 || aux_gnt !== 1'b0) begin
         errors++;
         $display("FAIL rst_after got=%h exp=%h", obs_v(), exp_v);
      end
      drive(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic test_random();
      bit lm = 1'b0;
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 15) == 0) lm = !lm;
         drive($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 7,
               16'($urandom_range(0, 31)), $urandom_range(0, 1) == 1,
               $urandom_range(0, 1) == 1, 16'($urandom_range(0, 31)),
               16'($urandom), lm);
         checks++;
         if (obs_v() !== exp_v) begin
            errors++;
            $display("FAIL random cyc=%0d got=%h exp=%h", cyc, obs_v(), exp_v);
         end
      end
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      cyc       = 0;
      have_eval = 1'b0;
      m_ph      = M_RUN;
      m_refused = 0;
      m_hold    = 1'b0;
      p_valid   = 1'b0;
      p_fetch   = 1'b0;
      p_data    = '0;
      for (int i = 0; i < 65536; i++) begin
         mem[i]     <= 16'(i) ^ 16'h5A5A;
         ref_mem[i]  = 16'(i) ^ 16'h5A5A;
      end
      mem[0]        <= 16'h1111;
      mem[1]        <= 16'h2222;
      mem[2]        <= 16'h3333;
      mem[16'h40]   <= 16'hC0DE;
      ref_mem[0]     = 16'h1111;
      ref_mem[1]     = 16'h2222;
      ref_mem[2]     = 16'h3333;
      ref_mem[16'h40] = 16'hC0DE;
      test_reset();
      test_fetch_seq();
      test_starve();
      test_aux_write();
      test_load();
      test_load_reset();
      test_reset_after_grant();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/imem_arbiter.md
Name: imem_arbiter

Overview:
- Shares the single instruction memory (one read port, one write port, 1-cycle registered read) between two requesters.
- Requester 1 is the CPU fetch stage; requester 2 is the aux port, used by the program/score loader and by data-side constant reads.
- The block sits between the fetch stage and the memory instance.
- It also sequences bulk program loading: it holds the CPU, drains any in-flight fetch, hands the memory to the loader, then releases the CPU.

Parameters:
ADDR_W, 16, memory address width
DATA_W, 16, instruction/data word width
MAX_WAIT, 4, cycles a pending aux request may be refused in RUN before it is forced through (legal range 1..15)

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous active-high reset
fetch_req  in  1  fetch stage wants a read this cycle
fetch_addr  in  ADDR_W  fetch read address
fetch_gnt  out  1  fetch read accepted this cycle (combinational)
fetch_rdata  out  DATA_W  fetch read data
fetch_rvalid  out  1  fetch_rdata valid (cycle after grant)
aux_req  in  1  aux wants an access this cycle
aux_we  in  1  1 = write, 0 = read
aux_addr  in  ADDR_W  aux address
aux_wdata  in  DATA_W  aux write data
aux_gnt  out  1  aux access accepted this cycle (combinational)
aux_rdata  out  DATA_W  aux read data
aux_rvalid  out  1  aux_rdata valid (cycle after a read grant)
load_mode  in  1  level request for exclusive loader ownership
cpu_hold  out  1  registered; fetch stage must treat as stall
mem_rdaddress  out  ADDR_W  to memory read address
mem_wraddress  out  ADDR_W  to memory write address
mem_wren  out  1  memory write enable
mem_data  out  DATA_W  memory write data
mem_q  in  DATA_W  memory read data (valid 1 cycle after address)

Behaviour:
- Grants: at most one grant per cycle; never fetch_gnt and aux_gnt together. Grants are combinational from req, state and wait_cnt.
- Memory mux:
  - Read addresses: mem_rdaddress = aux_addr when aux_gnt & !aux_we, else fetch_addr.
  - Writes: mem_wren = aux_gnt & aux_we; mem_wraddress = aux_addr; mem_data = aux_wdata.
  - An ungranted request never writes.
- Read return: a 1-bit registered owner tag plus a registered valid record each granted read. Next cycle, the matching rvalid pulses for exactly 1 cycle. fetch_rdata and aux_rdata both carry mem_q directly. Aux writes produce no rvalid.
- FSM states: RUN, DRAIN, LOAD.
- RUN:
  - fetch has priority.
  - aux is granted if fetch_req=0, or if aux_req & wait_cnt==MAX_WAIT.
  - wait_cnt (4-bit) increments, saturating, each cycle aux_req & !aux_gnt; it clears on aux_gnt or when aux_req=0.
- RUN -> DRAIN when load_mode=1. The request is sampled in RUN; that same cycle, no new fetch grant is issued.
- DRAIN:
  - No grants. cpu_hold=1 from the cycle after entry.
  - After 1 cycle, any outstanding read has returned; go to LOAD.
- LOAD:
  - aux_gnt = aux_req every cycle; fetch_gnt=0; cpu_hold=1; wait_cnt held at 0.
  - load_mode=0 -> RUN. cpu_hold deasserts the cycle after RUN is entered. An aux request in that first RUN cycle follows normal RUN arbitration.
- Simultaneous cases:
  - load_mode rising while aux_req is pending in RUN: that cycle follows RUN rules, except fetch is not granted (aux may win).
  - load_mode dropping in DRAIN: complete DRAIN, enter LOAD for 1 cycle, then RUN.
- Reset values: state RUN, wait_cnt 0, cpu_hold 0, both rvalid 0, owner tag 0.
  - A reset on the cycle after a grant suppresses that rvalid.
  - Reset while in LOAD returns to RUN with no write issued that cycle.
- Address/data widths pass through unmodified; no arithmetic on addresses.

Decomposition:
- Shared CPU package holds:
  - the state encoding constants (RUN=2'd0, DRAIN=2'd1, LOAD=2'd2);
  - the owner tag constants (OWN_FETCH=1'b0, OWN_AUX=1'b1);
  - ADDR_W/DATA_W defaults.
- One natural sub-module, imem_starve_counter, contains the saturating wait counter and its MAX_WAIT compare.
- Everything else lives in the top module.

Test Plan:
- Reset, then fetch_req=1 at addresses 0,1,2 with mem preloaded 0x1111,0x2222,0x3333 -> fetch_gnt every cycle; fetch_rvalid 1 cycle later with 0x1111,0x2222,0x3333; aux_rvalid stays 0.
- Fetch continuous, aux read 0x0040 held with MAX_WAIT=4 -> aux refused 4 cycles, granted on 5th cycle with fetch_gnt=0; aux_rvalid next cycle with mem[0x0040]; wait_cnt back to 0.
- Fetch idle, aux write addr 0x0010 data 0xBEEF -> aux_gnt same cycle; mem_wren=1 for 1 cycle; a later fetch of 0x0010 returns 0xBEEF.
- Fetch granted read, then load_mode=1 next cycle -> fetch_rvalid still delivered; DRAIN for 1 cycle; cpu_hold=1; LOAD accepts aux writes 0x0000..0x0003 back-to-back; fetch_gnt stays 0 throughout.
- load_mode drops in LOAD -> RUN next cycle; cpu_hold low the following cycle; fetch at 0x0000 returns the newly loaded word.
- Assert rst the cycle after a fetch grant -> no fetch_rvalid; state RUN, cpu_hold 0, wait_cnt 0 next cycle.
